// File: rtl/pipe_ctrl_unit_pkg.sv
// rtl/pipe_ctrl_unit_pkg.sv - shared exception codes, vector offsets and FSM state type
package pipe_ctrl_unit_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] VEC_INT_OFF = 32'h0000_0020;
  localparam logic [31:0] VEC_EXC_OFF = 32'h0000_0040;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_unit_stall_mask_gen.sv
// rtl/pipe_ctrl_unit_stall_mask_gen.sv - merges stall requests into a per-stage stall mask
module stall_mask_gen
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int                  NSTAGE    = 6,
  parameter int                  NSRC      = 4,
  parameter logic [3*NSRC-1:0]   SRC_STAGE = {3'd4, 3'd3, 3'd2, 3'd1}
) (
  input  logic [NSRC-1:0]   stallreq_i,
  output logic [NSTAGE-1:0] stall_mask_o
);

  // A source stalls its own stage and everything upstream; out-of-range stages clamp to the last.
  function automatic int stage_of(input int src);
    int stg;
    stg = int'(SRC_STAGE[3*src +: 3]);
    if (stg >= NSTAGE) stg = NSTAGE - 1;
    return stg;
  endfunction

  always_comb begin
    stall_mask_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (stallreq_i[i] == STOP) begin
        for (int j = 0; j < NSTAGE; j++) begin
          if (j <= stage_of(i)) stall_mask_o[j] = STOP;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipeline stall/flush control with exception redirect, watchdog and stall counter
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int                NSTAGE       = 6,
  parameter int                NSRC         = 4,
  parameter logic [3*NSRC-1:0] SRC_STAGE    = {3'd4, 3'd3, 3'd2, 3'd1},
  parameter int                DW           = 32,
  parameter logic [DW-1:0]     EXC_BASE     = '0,
  parameter int                FLUSH_CYCLES = 1,
  parameter int                WD_LIMIT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   stallreq_i,
  input  logic [31:0]       excepttype_i,
  input  logic [DW-1:0]     cp0_epc_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [DW-1:0]     new_pc_o,
  output logic              busy_o,
  output logic              stall_timeout_o,
  output logic [31:0]       stall_cycles_o,
  output logic              bad_exc_o
);

  localparam int HCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WCW = $clog2(WD_LIMIT + 1);

  state_e             state_q, state_d;
  logic [HCW-1:0]     hold_q, hold_d;
  logic [WCW-1:0]     wd_q, wd_d;
  logic               timeout_q, timeout_d;
  logic [31:0]        cyc_q, cyc_d;
  logic [DW-1:0]      pc_q, pc_d;
  logic [NSTAGE-1:0]  mask;
  logic [DW-1:0]      target;
  logic               known;
  logic               stall_any;

  stall_mask_gen #(
    .NSTAGE   (NSTAGE),
    .NSRC     (NSRC),
    .SRC_STAGE(SRC_STAGE)
  ) u_mask (
    .stallreq_i  (stallreq_i),
    .stall_mask_o(mask)
  );

  always_comb begin
    known  = 1'b1;
    target = EXC_BASE + DW'(VEC_EXC_OFF);
    case (excepttype_i)
      EXC_INT:                            target = EXC_BASE + DW'(VEC_INT_OFF);
      EXC_SYS, EXC_INV, EXC_OV, EXC_TRAP: target = EXC_BASE + DW'(VEC_EXC_OFF);
      EXC_ERET:                           target = cp0_epc_i;
      default:                            known  = 1'b0;
    endcase
  end

  // Exceptions and HOLD override stalls; reset forces every combinational output low.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pc_d      = pc_q;
    stall_o   = '0;
    flush_o   = 1'b0;
    new_pc_o  = '0;
    busy_o    = 1'b0;
    bad_exc_o = 1'b0;
    if (rst_n != RST_ENABLE) begin
      case (state_q)
        ST_IDLE: begin
          if (excepttype_i != '0) begin
            flush_o   = 1'b1;
            new_pc_o  = target;
            bad_exc_o = ~known;
            pc_d      = target;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_HOLD;
              hold_d  = HCW'(FLUSH_CYCLES - 1);
            end
          end else begin
            stall_o = mask;
          end
        end
        ST_HOLD: begin
          flush_o  = 1'b1;
          new_pc_o = pc_q;
          busy_o   = 1'b1;
          hold_d   = hold_q - 1'b1;
          if (hold_q <= HCW'(1)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Flush forces stall_o to zero, so the watchdog also clears during a flush.
  always_comb begin
    stall_any = |stall_o;
    if (!stall_any)                 wd_d = '0;
    else if (wd_q != WCW'(WD_LIMIT)) wd_d = wd_q + 1'b1;
    else                            wd_d = wd_q;
    timeout_d = timeout_q | (wd_d == WCW'(WD_LIMIT));
    cyc_d     = cyc_q + {31'b0, stall_any};
  end

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      cyc_q     <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      cyc_q     <= cyc_d;
      pc_q      <= pc_d;
    end
  end

  assign stall_timeout_o = timeout_q;
  assign stall_cycles_o  = cyc_q;

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised pipeline control unit for the tinyMIPS core. It merges N stall requests into a per-stage stall mask and decodes exception types into flush and new-PC redirects. It holds flush for a configurable number of cycles and adds a stall watchdog and a stall-cycle performance counter. It sits beside the pipeline and drives the stall/flush inputs of every pipeline register and the PC unit.

Parameters:
NSTAGE, 6, number of stall bits (bit0 = PC, bit k = pipeline register k)
NSRC, 4, number of stall-request sources
SRC_STAGE, {3'd4,3'd3,3'd2,3'd1}, packed 3-bit deepest stage index per source; source i uses bits [3i+2:3i]
DW, 32, PC/data width
EXC_BASE, 32'h00000000, exception vector base
FLUSH_CYCLES, 1, cycles flush_o stays high per accepted exception (>=1)
WD_LIMIT, 255, consecutive stall cycles before the watchdog trips (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stallreq_i  in  NSRC  stall request per source, 1 = stop
excepttype_i  in  32  exception code from the commit stage, 0 = none
cp0_epc_i  in  DW  EPC for ERET
stall_o  out  NSTAGE  per-stage stall mask
flush_o  out  1  pipeline flush
new_pc_o  out  DW  redirect target, valid while flush_o=1
busy_o  out  1  FSM in HOLD state
stall_timeout_o  out  1  sticky watchdog flag
stall_cycles_o  out  32  count of cycles with stall_o != 0
bad_exc_o  out  1  one-cycle pulse on an unknown nonzero excepttype_i

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; hold counter=0; watchdog counter=0; stall_timeout_o=0; stall_cycles_o=0; latched PC=0. While rst_n=0, combinational outputs are forced: stall_o=0, flush_o=0, new_pc_o=0, bad_exc_o=0, busy_o=0. Reset mid-HOLD aborts the flush immediately.
- Stall mask (combinational): source i active -> bits [SRC_STAGE_i:0] set. stall_o = OR over active sources. SRC_STAGE_i >= NSTAGE is clamped to NSTAGE-1. Defaults reproduce the classic codes: ID -> 000111, EX -> 001111.
- Exception decode (IDLE, excepttype_i != 0):
  - 0x1 -> EXC_BASE+0x20
  - 0x8, 0xa, 0xc, 0xd -> EXC_BASE+0x40
  - 0xe -> cp0_epc_i
  - any other nonzero code -> EXC_BASE+0x40, plus bad_exc_o=1 that cycle
- Timing: flush_o=1 and new_pc_o are driven combinationally in the same cycle. stall_o is forced to 0. The target is latched at the next posedge.
- FSM IDLE/HOLD:
  - IDLE -> HOLD on an accepted exception if FLUSH_CYCLES>1; the counter loads FLUSH_CYCLES-1.
  - In HOLD: flush_o=1, new_pc_o=latched target, stall_o=0, busy_o=1. excepttype_i is ignored (no re-accept, no bad_exc_o). The counter decrements each cycle; HOLD -> IDLE when it reaches 1.
  - FLUSH_CYCLES=1 never enters HOLD.
- Simultaneous events: exception or HOLD beats any stall request. With no exception, new_pc_o=0.
- Watchdog: the counter increments each cycle stall_o != 0 and clears when stall_o == 0. On reaching WD_LIMIT it saturates and sets stall_timeout_o, which stays high until reset. The counter clears on flush.
- Perf counter: stall_cycles_o += 1 on each cycle with stall_o != 0. It wraps modulo 2^32.

Decomposition:
- Shared header (with the existing macro include): exception codes (EXC_INT=0x1, EXC_SYS=0x8, EXC_INV=0xa, EXC_TRAP=0xd, EXC_OV=0xc, EXC_ERET=0xe), vector offsets 0x20/0x40, Stop/RstEnable encodings.
- One sub-module, stall_mask_gen: combinational; NSRC requests plus SRC_STAGE in, NSTAGE mask out.
- Exception decode, FSM and counters stay in the top module.

Test Plan:
- Reset: rst_n=0 with all inputs active -> all outputs 0. Release, stallreq_i=4'b0010 -> stall_o=6'b000111, flush_o=0.
- Stall priority: stallreq_i=4'b0110 -> stall_o=6'b001111. After 5 such cycles -> stall_cycles_o=5.
- Exception over stall: excepttype_i=0x8 and stallreq_i=4'b1000 in the same cycle -> flush_o=1, new_pc_o=0x40, stall_o=0.
- ERET hold (FLUSH_CYCLES=3): excepttype_i=0xe, cp0_epc_i=0x1234 for 1 cycle, then 0x1 next cycle -> flush_o=1 for 3 cycles, new_pc_o=0x1234 throughout, busy_o=1 on cycles 2-3, interrupt ignored.
- Unknown code: excepttype_i=0x5 -> new_pc_o=0x40, bad_exc_o pulses for 1 cycle.
- Watchdog (WD_LIMIT=4): stallreq_i held for 4 cycles -> stall_timeout_o=1 and stays 1 after the stall clears. Reset asserted mid-HOLD -> flush_o=0 the same cycle and busy_o=0 after the next edge.
